// File: rtl/vend_panel_arbiter_if.sv
// Signal bundle between the two customer panels, the shared vending core and vend_panel_arbiter.
// The slave modport is the arbiter's view; the master modport is the panels-plus-core side.
interface vend_panel_arbiter_if;
    // Handshake: a panel holds REQ[p] as a level until GRANT[p] is seen. GRANT stays one-hot for
    // the whole transaction. Exactly one DONE_OK[p] or DONE_FAIL[p] cycle closes it, after which
    // GRANT drops. KEY_PRESS is a one-cycle strobe that qualifies ITEM_CODE_p in the same cycle.
    logic [1:0] REQ;
    logic [1:0] KEY_PRESS;
    logic [3:0] ITEM_CODE_0;
    logic [3:0] ITEM_CODE_1;
    logic       CORE_VEND;
    logic       CORE_INVALID_SEL;
    logic       CORE_FAILED_TRAN;
    logic [2:0] CORE_COST;
    logic       CORE_CARD_IN;
    logic       CORE_KEY_PRESS;
    logic [3:0] CORE_ITEM_CODE;
    logic [1:0] GRANT;
    logic       BUSY;
    logic [1:0] DONE_OK;
    logic [1:0] DONE_FAIL;
    logic [2:0] COST_OUT;
    logic [2:0] STATE_DBG;

    modport slave (
        input  REQ, KEY_PRESS, ITEM_CODE_0, ITEM_CODE_1,
               CORE_VEND, CORE_INVALID_SEL, CORE_FAILED_TRAN, CORE_COST,
        output CORE_CARD_IN, CORE_KEY_PRESS, CORE_ITEM_CODE, GRANT, BUSY,
               DONE_OK, DONE_FAIL, COST_OUT, STATE_DBG
    );

    modport master (
        output REQ, KEY_PRESS, ITEM_CODE_0, ITEM_CODE_1,
               CORE_VEND, CORE_INVALID_SEL, CORE_FAILED_TRAN, CORE_COST,
        input  CORE_CARD_IN, CORE_KEY_PRESS, CORE_ITEM_CODE, GRANT, BUSY,
               DONE_OK, DONE_FAIL, COST_OUT, STATE_DBG
    );
endinterface

// File: rtl/vend_panel_arbiter.sv
// Round-robin arbiter sharing one vending core between two panels, with a per-transaction watchdog.
// Optional VEND_STATS_EN adds saturating completed-vend counters VEND_CNT_0/VEND_CNT_1.
module vend_panel_arbiter #(
    parameter int unsigned WDOG_CYC = 64
) (
    input  logic CLK,
    input  logic RESET,
    vend_panel_arbiter_if.slave bus
`ifdef VEND_STATS_EN
    ,
    output logic [7:0] VEND_CNT_0,
    output logic [7:0] VEND_CNT_1
`endif
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CARD    = 3'd1,
        S_ACTIVE  = 3'd2,
        S_VENDING = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [7:0] WDOG_LAST = 8'(WDOG_CYC - 1);

    state_t     state, state_nxt;
    logic       owner, owner_nxt;
    logic       last;
    logic       ok, ok_nxt;
    logic       latch_cost;
    logic [7:0] wdog;
    logic [2:0] cost_q;
    logic [1:0] owner_hot;
    logic       wdog_hit;
    logic       core_fail;

    assign wdog_hit  = (wdog == WDOG_LAST);
    assign core_fail = bus.CORE_INVALID_SEL | bus.CORE_FAILED_TRAN;
    assign owner_hot = owner ? 2'b10 : 2'b01;

    always_comb begin
        state_nxt          = state;
        owner_nxt          = owner;
        ok_nxt             = ok;
        latch_cost         = 1'b0;
        bus.GRANT          = 2'b00;
        bus.CORE_CARD_IN   = 1'b0;
        bus.CORE_KEY_PRESS = 1'b0;
        bus.CORE_ITEM_CODE = 4'd0;
        bus.DONE_OK        = 2'b00;
        bus.DONE_FAIL      = 2'b00;
        case (state)
            S_IDLE: begin
                if (bus.REQ != 2'b00) begin
                    state_nxt = S_CARD;
                    // On a tie the panel that did not win last time goes first.
                    owner_nxt = (bus.REQ == 2'b11) ? ~last : bus.REQ[1];
                end
            end
            S_CARD: begin
                bus.GRANT        = owner_hot;
                bus.CORE_CARD_IN = 1'b1;
                state_nxt        = S_ACTIVE;
            end
            S_ACTIVE: begin
                bus.GRANT          = owner_hot;
                bus.CORE_KEY_PRESS = bus.KEY_PRESS[owner];
                bus.CORE_ITEM_CODE = owner ? bus.ITEM_CODE_1 : bus.ITEM_CODE_0;
                if (wdog_hit || core_fail) begin
                    state_nxt = S_DONE;
                    ok_nxt    = 1'b0;
                end else if (bus.CORE_VEND) begin
                    state_nxt  = S_VENDING;
                    latch_cost = 1'b1;
                end
            end
            S_VENDING: begin
                bus.GRANT = owner_hot;
                if (wdog_hit) begin
                    state_nxt = S_DONE;
                    ok_nxt    = 1'b0;
                end else if (!bus.CORE_VEND) begin
                    state_nxt = S_DONE;
                    ok_nxt    = 1'b1;
                end
            end
            S_DONE: begin
                bus.GRANT     = owner_hot;
                bus.DONE_OK   = ok ? owner_hot : 2'b00;
                bus.DONE_FAIL = ok ? 2'b00 : owner_hot;
                state_nxt     = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state  <= S_IDLE;
            owner  <= 1'b0;
            last   <= 1'b1;
            ok     <= 1'b0;
            wdog   <= 8'd0;
            cost_q <= 3'd0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            ok    <= ok_nxt;
            if (state == S_CARD) begin
                last <= owner;
                wdog <= 8'd0;
            end else if (state == S_ACTIVE || state == S_VENDING) begin
                wdog <= wdog + 8'd1;
            end
            // Cost is cleared at each new grant so a failed transaction never shows a stale price.
            if (state == S_IDLE && state_nxt == S_CARD) begin
                cost_q <= 3'd0;
            end else if (latch_cost) begin
                cost_q <= bus.CORE_COST;
            end
        end
    end

    assign bus.BUSY      = (state != S_IDLE);
    assign bus.COST_OUT  = cost_q;
    assign bus.STATE_DBG = state;

`ifdef VEND_STATS_EN
    always_ff @(posedge CLK) begin
        if (RESET) begin
            VEND_CNT_0 <= 8'd0;
            VEND_CNT_1 <= 8'd0;
        end else if (state == S_DONE && ok) begin
            if (!owner && VEND_CNT_0 != 8'hFF) VEND_CNT_0 <= VEND_CNT_0 + 8'd1;
            if (owner && VEND_CNT_1 != 8'hFF) VEND_CNT_1 <= VEND_CNT_1 + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vend_panel_arbiter.sv
// Bench for vend_panel_arbiter: transaction-level reference model feeding an expected-outcome queue
// that a monitor drains on every DONE pulse; inline checks cover grant, card and key forwarding.
module tb_vend_panel_arbiter;
    localparam int WDOG = 8;

    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    vend_panel_arbiter_if bus_if ();
`ifdef VEND_STATS_EN
    logic [7:0] cnt0, cnt1;
`endif

    vend_panel_arbiter #(.WDOG_CYC(WDOG)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus_if)
`ifdef VEND_STATS_EN
        ,
        .VEND_CNT_0 (cnt0),
        .VEND_CNT_1 (cnt1)
`endif
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned cyc     = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // {done cycle, DONE_OK, DONE_FAIL, COST_OUT}
    logic [38:0] exp_q[$];

    // Reference model state
    bit m_last;
    int m_cnt[2];

    // Transaction descriptor: kind 0 silent core, 1 fail, 2 vend, 3 fail together with vend
    logic [1:0] t_req;
    int         t_kind, t_c, t_h, t_keys, t_other_code;
    logic [3:0] t_code[8];
    logic [2:0] t_cost;
    bit         t_drop;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic quiet_core();
        bus_if.KEY_PRESS        = 2'b00;
        bus_if.ITEM_CODE_0      = 4'd0;
        bus_if.ITEM_CODE_1      = 4'd0;
        bus_if.CORE_VEND        = 1'b0;
        bus_if.CORE_INVALID_SEL = 1'b0;
        bus_if.CORE_FAILED_TRAN = 1'b0;
        bus_if.CORE_COST        = 3'd0;
    endtask

    task automatic do_reset();
        RESET      = 1'b1;
        bus_if.REQ = 2'b00;
        quiet_core();
        tick();
        tick();
        RESET    = 1'b0;
        m_last   = 1'b1;
        m_cnt[0] = 0;
        m_cnt[1] = 0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_grant"}, bus_if.GRANT, 2'b00);
        check({tag, "_busy"}, bus_if.BUSY, 1'b0);
        check({tag, "_card_in"}, bus_if.CORE_CARD_IN, 1'b0);
        check({tag, "_core_key"}, bus_if.CORE_KEY_PRESS, 1'b0);
        check({tag, "_core_code"}, bus_if.CORE_ITEM_CODE, 4'd0);
        check({tag, "_done"}, {bus_if.DONE_OK, bus_if.DONE_FAIL}, 4'd0);
    endtask

    task automatic run_txn();
        bit         own, okx, latched, own_key, oth_key, in_active;
        logic [1:0] hot, r;
        logic [2:0] cexp;
        logic [3:0] oth_code;
        int         e, didx, a;

        own    = (t_req == 2'b11) ? ~m_last : t_req[1];
        m_last = own;
        hot    = own ? 2'b10 : 2'b01;

        case (t_kind)
            0:       e = 1000;
            2:       e = t_c + t_h;
            default: e = t_c;
        endcase
        didx    = (e < WDOG) ? e : WDOG;
        okx     = (t_kind == 2) && (e < WDOG);
        latched = (t_kind == 2) && (t_c < WDOG);
        cexp    = latched ? t_cost : 3'd0;
        if (okx && m_cnt[own] < 255) m_cnt[own]++;

        bus_if.REQ = t_req;
        tick();
        bus_if.KEY_PRESS   = 2'b11;
        bus_if.ITEM_CODE_0 = 4'($urandom_range(0, 15));
        bus_if.ITEM_CODE_1 = 4'($urandom_range(0, 15));
        #1;
        check("card_grant", bus_if.GRANT, hot);
        check("card_in", bus_if.CORE_CARD_IN, 1'b1);
        check("card_busy", bus_if.BUSY, 1'b1);
        check("card_key_blocked", bus_if.CORE_KEY_PRESS, 1'b0);
        tick();

        a = int'(cyc);
        exp_q.push_back({32'(a + didx), okx ? hot : 2'b00, okx ? 2'b00 : hot, cexp});
        if (t_drop) bus_if.REQ = 2'b00;

        for (int i = 1; i <= didx; i++) begin
            own_key  = (i <= t_keys);
            oth_key  = (t_other_code >= 0) ? 1'b1 : 1'($urandom_range(0, 1));
            oth_code = (t_other_code >= 0) ? 4'(t_other_code) : 4'($urandom_range(0, 15));
            if (own) begin
                bus_if.KEY_PRESS   = {own_key, oth_key};
                bus_if.ITEM_CODE_1 = t_code[i-1];
                bus_if.ITEM_CODE_0 = oth_code;
            end else begin
                bus_if.KEY_PRESS   = {oth_key, own_key};
                bus_if.ITEM_CODE_0 = t_code[i-1];
                bus_if.ITEM_CODE_1 = oth_code;
            end
            bus_if.CORE_VEND = ((t_kind == 2) && i >= t_c && i < t_c + t_h) || ((t_kind == 3) && i == t_c);
            r = ((t_kind == 1 || t_kind == 3) && i == t_c) ? 2'($urandom_range(1, 3)) : 2'b00;
            bus_if.CORE_INVALID_SEL = r[0];
            bus_if.CORE_FAILED_TRAN = r[1];
            bus_if.CORE_COST = ((t_kind == 2) && i == t_c) ? t_cost : 3'($urandom_range(0, 7));
            #1;
            in_active = !((t_kind == 2) && i > t_c);
            check("txn_grant", bus_if.GRANT, hot);
            check("txn_busy", bus_if.BUSY, 1'b1);
            check("txn_card_in_low", bus_if.CORE_CARD_IN, 1'b0);
            check("key_fwd", bus_if.CORE_KEY_PRESS, in_active ? own_key : 1'b0);
            check("code_fwd", bus_if.CORE_ITEM_CODE, in_active ? t_code[i-1] : 4'd0);
            tick();
        end

        quiet_core();
        #1;
        check("done_grant_held", bus_if.GRANT, hot);
        check("done_core_key", bus_if.CORE_KEY_PRESS, 1'b0);
        tick();
        check("after_done_grant", bus_if.GRANT, 2'b00);
        check("after_done_busy", bus_if.BUSY, 1'b0);
    endtask

    task automatic set_txn(input logic [1:0] req, input int kind, input int c, input int h,
                           input int keys, input logic [2:0] cost);
        t_req        = req;
        t_kind       = kind;
        t_c          = c;
        t_h          = h;
        t_keys       = keys;
        t_cost       = cost;
        t_drop       = 1'b0;
        t_other_code = -1;
        for (int i = 0; i < 8; i++) t_code[i] = 4'($urandom_range(0, 15));
    endtask

    always @(negedge CLK) begin
        logic [38:0] act, exp_v;
        if (!RESET && (bus_if.DONE_OK != 2'b00 || bus_if.DONE_FAIL != 2'b00)) begin
            act = {32'(cyc), bus_if.DONE_OK, bus_if.DONE_FAIL, bus_if.COST_OUT};
            if (exp_q.size() == 0) begin
                check("unexpected_done", act, 39'd0);
            end else begin
                exp_v = exp_q.pop_front();
                check("done_event", act, exp_v);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL sim_timeout: simulation did not finish, stopping at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        do_reset();
        bus_if.KEY_PRESS = 2'b11;
        #1;
        check_idle_outputs("reset");
        check("reset_cost", bus_if.COST_OUT, 3'd0);
`ifdef VEND_STATS_EN
        check("reset_cnt", {cnt0, cnt1}, 16'd0);
`endif
        quiet_core();

        // Ties after reset: panel 0 first, then panel 1 with REQ held
        set_txn(2'b11, 2, 2, 2, 1, 3'd5);
        run_txn();
        set_txn(2'b11, 2, 1, 2, 0, 3'd6);
        run_txn();

        // Panel 1 alone: keys 1 then 4, vend held 3 cycles at cost 4
        set_txn(2'b10, 2, 3, 3, 2, 3'd4);
        t_code[0] = 4'd1;
        t_code[1] = 4'd4;
        run_txn();

        // Panel 0 owns while panel 1 keeps pressing code 7; invalid selection ends it
        set_txn(2'b01, 1, 4, 1, 0, 3'd0);
        t_other_code = 7;
        run_txn();

        // Same-cycle fail and vend take the fail path; REQ dropped mid-transaction
        set_txn(2'b10, 3, 2, 1, 1, 3'd0);
        t_drop = 1'b1;
        run_txn();

        // Silent core: watchdog expiry
        set_txn(2'b01, 0, 1, 1, 2, 3'd0);
        run_txn();
        // Vend that outlasts the watchdog
        set_txn(2'b10, 2, 2, 9, 0, 3'd3);
        run_txn();

        // Reset during VENDING aborts with no DONE pulse
        bus_if.REQ = 2'b01;
        tick();
        tick();
        bus_if.CORE_VEND = 1'b1;
        bus_if.CORE_COST = 3'd5;
        tick();
        check("vending_busy", bus_if.BUSY, 1'b1);
        RESET = 1'b1;
        tick();
        check_idle_outputs("abort");
        check("abort_cost", bus_if.COST_OUT, 3'd0);
        RESET = 1'b0;
        bus_if.REQ = 2'b00;
        quiet_core();
        m_last   = 1'b1;
        m_cnt[0] = 0;
        m_cnt[1] = 0;
        tick();
        check("abort_idle_busy", bus_if.BUSY, 1'b0);

        // Randomized transactions with occasional idle gaps
        for (int n = 0; n < 80; n++) begin
            set_txn(2'($urandom_range(1, 3)), int'($urandom_range(0, 3)), int'($urandom_range(1, WDOG + 1)),
                    int'($urandom_range(1, 5)), int'($urandom_range(0, 3)), 3'($urandom_range(0, 7)));
            t_drop = 1'($urandom_range(0, 1));
            run_txn();
            if ($urandom_range(0, 3) == 0) begin
                bus_if.REQ = 2'b00;
                tick();
                check("gap_busy", bus_if.BUSY, 1'b0);
            end
        end
`ifdef VEND_STATS_EN
        check("rand_cnt0", cnt0, 8'(m_cnt[0]));
        check("rand_cnt1", cnt1, 8'(m_cnt[1]));
`endif

        // 257 completed vends on panel 0 for counter saturation
        do_reset();
        for (int n = 0; n < 257; n++) begin
            set_txn(2'b01, 2, 1, 1, 0, 3'($urandom_range(0, 7)));
            run_txn();
        end
`ifdef VEND_STATS_EN
        check("sat_cnt0_model", cnt0, 8'(m_cnt[0]));
        check("sat_cnt0", cnt0, 8'd255);
        check("sat_cnt1", cnt1, 8'd0);
`endif

        bus_if.REQ = 2'b00;
        tick();
        tick();
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
